// File: rtl/bp_me_clint_fwd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_clint_fwd_arbiter
// Brief    : Round-robin arbiter sharing one CLINT slice BedRock port between
//            NUM_REQ requesters, one outstanding transaction at a time.
//            Optional response timeout: define BP_ME_CLINT_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bp_me_clint_fwd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int HEADER_WIDTH   = 128,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int LG_REQ        = $clog2(NUM_REQ)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [NUM_REQ*HEADER_WIDTH-1:0] req_fwd_header_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_fwd_data_i,
    input  logic [NUM_REQ-1:0]              req_fwd_v_i,
    output logic [NUM_REQ-1:0]              req_fwd_ready_and_o,

    output logic [HEADER_WIDTH-1:0]         req_rev_header_o,
    output logic [DATA_WIDTH-1:0]           req_rev_data_o,
    output logic [NUM_REQ-1:0]              req_rev_v_o,
    input  logic [NUM_REQ-1:0]              req_rev_ready_and_i,

    output logic [HEADER_WIDTH-1:0]         mem_fwd_header_o,
    output logic [DATA_WIDTH-1:0]           mem_fwd_data_o,
    output logic                            mem_fwd_v_o,
    input  logic                            mem_fwd_ready_and_i,

    input  logic [HEADER_WIDTH-1:0]         mem_rev_header_i,
    input  logic [DATA_WIDTH-1:0]           mem_rev_data_i,
    input  logic                            mem_rev_v_i,
    output logic                            mem_rev_ready_and_o,

    output logic [LG_REQ-1:0]               owner_o,
    output logic                            timeout_o
);

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_SEND = 2'd1,
        E_WAIT = 2'd2
    } state_e;

    state_e              r_state;
    logic [LG_REQ-1:0]   r_owner;
    logic [LG_REQ-1:0]   r_last;
    logic [LG_REQ-1:0]   w_pick;
    logic                w_any_v;
    logic                w_fwd_hs;
    logic                w_rev_hs;

    logic [HEADER_WIDTH-1:0] w_hdr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   w_dat [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_hdr[g] = req_fwd_header_i[g*HEADER_WIDTH +: HEADER_WIDTH];
        assign w_dat[g] = req_fwd_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from farthest offset to nearest so the nearest valid after r_last wins.
    always_comb begin
        logic [LG_REQ:0] scan;
        w_pick  = '0;
        w_any_v = 1'b0;
        scan    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            scan = {1'b0, r_last} + (LG_REQ+1)'(i);
            if (scan >= (LG_REQ+1)'(NUM_REQ)) begin
                scan = scan - (LG_REQ+1)'(NUM_REQ);
            end
            if (req_fwd_v_i[scan[LG_REQ-1:0]]) begin
                w_pick  = scan[LG_REQ-1:0];
                w_any_v = 1'b1;
            end
        end
    end

    assign mem_fwd_header_o = w_hdr[r_owner];
    assign mem_fwd_data_o   = w_dat[r_owner];
    assign req_rev_header_o = mem_rev_header_i;
    assign req_rev_data_o   = mem_rev_data_i;
    assign owner_o          = r_owner;

    // Handshake outputs are held low while reset is asserted.
    always_comb begin
        req_fwd_ready_and_o = '0;
        req_rev_v_o         = '0;
        mem_fwd_v_o         = 1'b0;
        mem_rev_ready_and_o = 1'b0;
        if (!reset_i) begin
            case (r_state)
                E_IDLE: mem_rev_ready_and_o = 1'b1;
                E_SEND: begin
                    mem_fwd_v_o                  = req_fwd_v_i[r_owner];
                    req_fwd_ready_and_o[r_owner] = mem_fwd_ready_and_i;
                end
                E_WAIT: begin
                    req_rev_v_o[r_owner] = mem_rev_v_i;
                    mem_rev_ready_and_o  = req_rev_ready_and_i[r_owner];
                end
                default: ;
            endcase
        end
    end

    assign w_fwd_hs = mem_fwd_v_o & mem_fwd_ready_and_i;
    assign w_rev_hs = mem_rev_v_i & mem_rev_ready_and_o;

`ifdef BP_ME_CLINT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    assign timeout_o = r_timeout;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= E_IDLE;
            r_owner   <= '0;
            r_last    <= LG_REQ'(NUM_REQ - 1);
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                E_IDLE: if (w_any_v) begin
                    r_owner <= w_pick;
                    r_state <= E_SEND;
                end
                E_SEND: if (w_fwd_hs) begin
                    r_last  <= r_owner;
                    r_cnt   <= '0;
                    r_state <= E_WAIT;
                end
                E_WAIT: begin
                    // Count reaches TIMEOUT_CYCLES on the same edge we leave.
                    if (w_rev_hs) begin
                        r_state <= E_IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= E_IDLE;
                        r_timeout <= 1'b1;
                        r_cnt     <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= E_IDLE;
            endcase
        end
    end
`else
    assign timeout_o = 1'b0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= E_IDLE;
            r_owner <= '0;
            r_last  <= LG_REQ'(NUM_REQ - 1);
        end else begin
            case (r_state)
                E_IDLE: if (w_any_v) begin
                    r_owner <= w_pick;
                    r_state <= E_SEND;
                end
                E_SEND: if (w_fwd_hs) begin
                    r_last  <= r_owner;
                    r_state <= E_WAIT;
                end
                E_WAIT: if (w_rev_hs) begin
                    r_state <= E_IDLE;
                end
                default: r_state <= E_IDLE;
            endcase
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/bp_me_clint_fwd_arbiter.md
Name: bp_me_clint_fwd_arbiter

Overview:
- Round-robin arbiter that shares one CLINT slice BedRock port between num_req_p requesters, e.g. per-core I/O paths or a debug/loopback master.
- Sits between the requesters and the CLINT slice's mem_fwd/mem_rev interface.
- Allows one outstanding transaction at a time and routes the mem_rev response back to the requester that issued it.

Parameters:
- num_req_p, 4, number of requesters; must be ≥2.
- header_width_p, 128, width of the opaque mem_fwd/mem_rev header, equal to mem_fwd_header_width_lp.
- data_width_p, 64, fill data width, equal to bedrock_fill_width_p.
- timeout_cycles_p, 1024, response timeout in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- req_fwd_header_i  in  num_req_p*header_width_p  per-requester fwd header
- req_fwd_data_i  in  num_req_p*data_width_p  per-requester fwd data
- req_fwd_v_i  in  num_req_p  per-requester fwd valid
- req_fwd_ready_and_o  out  num_req_p  per-requester fwd ready
- req_rev_header_o  out  header_width_p  rev header, broadcast to all requesters
- req_rev_data_o  out  data_width_p  rev data, broadcast to all requesters
- req_rev_v_o  out  num_req_p  one-hot rev valid, asserted to the owner only
- req_rev_ready_and_i  in  num_req_p  per-requester rev ready
- mem_fwd_header_o  out  header_width_p  to slice
- mem_fwd_data_o  out  data_width_p  to slice
- mem_fwd_v_o  out  1  to slice
- mem_fwd_ready_and_i  in  1  from slice
- mem_rev_header_i  in  header_width_p  from slice
- mem_rev_data_i  in  data_width_p  from slice
- mem_rev_v_i  in  1  from slice
- mem_rev_ready_and_o  out  1  to slice
- owner_o  out  lg(num_req_p)  current or last granted requester index
- timeout_o  out  1  one-cycle pulse on response timeout

Behaviour:
- One clock (clk_i), synchronous active-high reset (reset_i).
- Reset values:
  - State = e_idle.
  - Round-robin pointer: last grant = num_req_p-1, so requester 0 has first priority.
  - owner_o = 0, all v/ready outputs = 0, timeout_o = 0.
- All handshakes are ready-and-valid; a transfer occurs on the cycle where v & ready_and are both high.
- State e_idle:
  - If any req_fwd_v_i is high, pick the first valid requester searching upward (wrapping) from last grant + 1.
  - Register the pick into owner_o and go to e_send.
  - No fwd ready is asserted in e_idle; arbitration costs one cycle.
  - mem_rev_ready_and_o = 1 in e_idle: stray responses are consumed and discarded.
- State e_send:
  - Present the owner's header and data on mem_fwd_*; mem_fwd_v_o = req_fwd_v_i[owner].
  - req_fwd_ready_and_o[owner] = mem_fwd_ready_and_i; all other ready outputs are 0.
  - On handshake: update the round-robin pointer to owner and go to e_wait.
  - If the owner drops valid before the handshake, stay in e_send (BedRock forbids retracting valid; the bench flags it).
- State e_wait:
  - req_rev_v_o[owner] = mem_rev_v_i; pass header and data through.
  - mem_rev_ready_and_o = req_rev_ready_and_i[owner].
  - On handshake go to e_idle.
- Every transaction returns to e_idle, so the minimum per-transaction cost is idle + send + 1 response cycle.
- A requester with continuous valid is regranted only after every other valid requester has been served once.
- Data path is combinational pass-through; there is no buffering.
- Reset asserted mid-transaction: the FSM returns to e_idle and the in-flight response is dropped by the e_idle sink.
- A simultaneous new request and response handshake cannot occur: only one outstanding transaction is allowed.

Optional Feature:
- Macro: BP_ME_CLINT_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(timeout_cycles_p+1) clears on entry to e_wait and increments each cycle in e_wait.
  - When it reaches timeout_cycles_p without a rev handshake, go to e_idle and pulse timeout_o for one cycle.
  - A late response is discarded in e_idle.
- When undefined:
  - The counter is absent, timeout_o is tied to 0, and e_wait waits indefinitely.

Test Plan:
- Single request: req 2 valid with header H, data 0xDEAD_BEEF; slice always ready and returns a response 3 cycles later.
  - Expected: mem_fwd_v_o rises the cycle after the request, one fwd handshake, req_rev_v_o = 4'b0100 with data intact, owner_o = 2.
- All 4 requesters valid continuously.
  - Expected: grant order 0, 1, 2, 3, 0; no requester granted twice within 4 transactions.
- Slice stalls: mem_fwd_ready_and_i low for 5 cycles in e_send.
  - Expected: mem_fwd_v_o held, header/data stable, no other requester's ready asserted.
- Owner rev backpressure: req_rev_ready_and_i[owner] = 0 for 4 cycles.
  - Expected: mem_rev_ready_and_o = 0 for those cycles, then one handshake and return to e_idle.
- Reset asserted in e_wait, slice responds 2 cycles after reset deasserts.
  - Expected: all outputs at reset values, response absorbed with no req_rev_v_o, next grant goes to req 0.
- With BP_ME_CLINT_ARB_TIMEOUT_EN and timeout_cycles_p = 16, no response.
  - Expected: timeout_o pulses exactly 16 cycles after the fwd handshake; a subsequent request from req 1 is served normally.
